uart_rx: RTL
============

# uart_rx

UART receiver: deserialises an 8N1 asynchronous serial line into bytes and pulses a one-cycle valid strobe per received frame. It sits directly downstream of `uart_tx` (loopback or off-chip link) and uses the same `CLK_PER_BIT` timing model, so a `uart_tx`/`uart_rx` pair with equal parameters interoperates. Each bit is sampled once at its centre. Start-bit glitches and bad stop bits are rejected or flagged.

## Interface
- `CLK_PER_BIT`, 87: clock cycles per serial bit; must be ≥ 4.
- `clk`  input  1  system clock; all logic on rising edge.
- `i_rst`  input  1  reset, synchronous, active-high.
- `i_rx`  input  1  serial line; idles high.
- `o_data`  output  8  last correctly framed byte; LSB received first.
- `o_valid`  output  1  one-cycle pulse when `o_data` updates.
- `o_frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `o_busy`  output  1  high whenever the state is not IDLE.
- `o_state`  output  2  current FSM state: IDLE=0, START=1, DATA=2, STOP=3.

## Operation
- `rx_s` is the line as seen by the FSM: `i_rx` after the optional synchroniser (see Configuration). `rx_prev` is `rx_s` registered one cycle.
- `HALF` = (`CLK_PER_BIT`-1)/2 (integer division). The bit counter is $clog2(`CLK_PER_BIT`) bits wide and the bit index is 3 bits.
- **IDLE**
  - On `rx_prev`=1 and `rx_s`=0 (falling edge): clear the counter and go to START.
  - A line held low never retriggers; a high must be seen first.
- **START**
  - When the counter reaches `HALF`, sample `rx_s`.
  - Sample 0: clear the counter and bit index, go to DATA.
  - Sample 1: glitch; go to IDLE with no output pulse.
- **DATA**
  - When the counter reaches `CLK_PER_BIT`-1, sample `rx_s` into shift bit [index] and clear the counter.
  - After index 7, go to STOP.
- **STOP**
  - When the counter reaches `CLK_PER_BIT`-1, sample `rx_s`.
  - Sample 1: load the shift register into `o_data` and pulse `o_valid`.
  - Sample 0: pulse `o_frame_err`; `o_data` keeps its old value.
  - Either way, go to IDLE immediately, at mid-stop-bit. This allows back-to-back frames with no idle gap.
- `o_valid` and `o_frame_err` are never high together.
- **Reset values:** `o_data`=0, `o_valid`=0, `o_frame_err`=0, `o_busy`=0, `o_state`=IDLE, shift register 0, counter 0. Synchroniser flops and `rx_prev` reset to 1.
- **Reset mid-frame:** the frame is aborted with no pulse. All outputs are at reset values after the reset edge. The next frame needs a fresh falling edge.

## Timing
- t0 is the edge at which IDLE detects the falling edge.
- Start sample at t0+1+`HALF`. Data bit k (k = 0..7) sampled `CLK_PER_BIT`·(k+1) cycles later. Stop sample at t0+1+`HALF`+9·`CLK_PER_BIT`.
- `o_valid`/`o_frame_err` are registered and high for exactly the one cycle after the stop sample.
- With `CLK_PER_BIT`=87: valid at t0+1+43+783+1 = t0+828.
- `o_busy` rises the cycle after t0 and falls in the same cycle as the `o_valid` pulse.
- Back-to-back frames: `o_valid` pulses are exactly 10·`CLK_PER_BIT` cycles apart.
- Per-edge tolerance: up to `HALF`-1 cycles of accumulated drift per frame.

## Configuration
- `UART_RX_SYNC_EN` defined:
  - `i_rx` passes through a two-flop synchroniser (reset value 1) before `rx_s`.
  - All latencies from the line grow by 2 cycles.
- Not defined: `rx_s` = `i_rx` directly. Use only when `i_rx` is already synchronous to `clk`, e.g. on-chip loopback from `uart_tx`.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants IDLE/START/DATA/STOP, also used by `uart_tx` for `o_state`;
  - `UART_DATA_W`=8.
- One sub-module, `uart_sync2`: the two-flop synchroniser with synchronous reset-to-1. It is instantiated only under `UART_RX_SYNC_EN`.
- Everything else (edge detect, FSM, counter, shift register, output registers) lives in `uart_rx`.

## Test plan
All tests use a 100 ns clock, `CLK_PER_BIT`=87, and macro off unless stated.
- **Loopback:** `uart_tx` sends 8'hAB into `i_rx` -> one `o_valid` pulse 828 cycles after the edge detect, `o_data`=8'hAB, `o_frame_err` never high.
- **Start glitch:** `i_rx` low for 20 cycles then high -> state returns IDLE at start sample (t0+44), `o_busy` low from t0+45, no `o_valid`/`o_frame_err`.
- **Frame error:** receive 8'h11, then drive 8'h55 with a 0 stop bit -> `o_frame_err` pulses once, `o_valid` stays low, `o_data` stays 8'h11.
- **Back-to-back:** 8'h00 then 8'hFF with zero idle gap -> two `o_valid` pulses exactly 870 cycles apart, data 8'h00 then 8'hFF.
- **Reset mid-frame:** assert `i_rst` for 1 cycle during DATA bit 3 -> all outputs 0/IDLE next cycle, no pulse; the following frame 8'h3C is received correctly.
- **`UART_RX_SYNC_EN` defined:** repeat the loopback test -> `o_valid` at t0+830 relative to the `i_rx` falling edge, `o_data`=8'hAB.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (also reported on o_state by uart_tx)
// and the data width.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; both flops reset to the
// line's idle level (1) so no false start edge appears out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, one centre sample per bit. Define UART_RX_SYNC_EN to insert a
// two-flop synchroniser on i_rx (adds 2 cycles of latency from the line).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 87
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_rx,
  output logic [UART_DATA_W-1:0] o_data,
  output logic                   o_valid,
  output logic                   o_frame_err,
  output logic                   o_busy,
  output logic [1:0]             o_state
);

  localparam int unsigned HALF  = (CLK_PER_BIT - 1) / 2;
  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

  logic                   w_rx_s;
  logic                   r_rx_prev;
  logic                   w_fall;
  logic                   w_half_hit;
  logic                   w_bit_hit;
  uart_state_e            r_state;
  uart_state_e            w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_valid;
  logic                   r_ferr;

`ifdef UART_RX_SYNC_EN
  uart_sync2 u_sync (
    .clk   (clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (w_rx_s)
  );
`else
  assign w_rx_s = i_rx;
`endif

  // rx_prev resets high, so a line already low must first return high to trigger.
  always_ff @(posedge clk) begin
    if (i_rst) r_rx_prev <= 1'b1;
    else       r_rx_prev <= w_rx_s;
  end

  assign w_fall     = r_rx_prev & ~w_rx_s;
  assign w_half_hit = (r_cnt == CNT_HALF);
  assign w_bit_hit  = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_state_nxt = START;
      START:   if (w_half_hit) w_state_nxt = w_rx_s ? IDLE : DATA;
      DATA:    if (w_bit_hit && (r_idx == 3'd7)) w_state_nxt = STOP;
      STOP:    if (w_bit_hit) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (r_state != IDLE);
    o_state = r_state;
  end

  // Returning to IDLE at mid-stop-bit leaves half a bit to catch the next start edge.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        IDLE: r_cnt <= '0;
        START: begin
          if (w_half_hit) begin
            r_cnt <= '0;
            r_idx <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_bit_hit) begin
            r_shift[r_idx] <= w_rx_s;
            r_idx          <= r_idx + 3'd1;
            r_cnt          <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (w_bit_hit) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;

endmodule
